dsp_ex_mem_stage: RTL and testbench

DSP_EX_MEM_STAGE -- requirements
Module: dsp_ex_mem_stage

---
 rtl/dsp_ex_mem_stage.sv | 116 +++++++++++
 tb/tb_dsp_ex_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_ex_mem_stage.sv
// Execute-to-memory pipeline register with store-to-load bank turnaround,
// load-use hazard detection and bypass of results that are already final.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal flow; a presented instruction is captured on every edge
// TURN  | one bubble was just inserted after a store; accept the re-presented load
module dsp_ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] data_s1_in,
    input  logic [15:0] data_s2_in,
    input  logic [2:0]  mem_mode_in,
    input  logic        write_back_en_in,
    input  logic [3:0]  dest_reg_in,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic        use_a,
    input  logic        use_b,
    input  logic        flush,
    output logic [15:0] alu_result,
    output logic [15:0] data_s1,
    output logic [15:0] data_s2,
    output logic [2:0]  mem_mode,
    output logic        write_back_en,
    output logic [3:0]  dest_reg,
    output logic        load_use_stall,
    output logic        fwd_valid,
    output logic [3:0]  fwd_reg,
    output logic [15:0] fwd_data
);

    localparam logic [2:0] MEM_NONE   = 3'd0;
    localparam logic [2:0] MEM_LD     = 3'd1;
    localparam logic [2:0] MEM_ST     = 3'd2;
    localparam logic [2:0] MEM_LD_IMM = 3'd3;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TURN = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   turn_hit;
    logic   mode_known;
    logic   capture;

    // Bit 15 of the address selects the SRAM bank; only a same-bank load
    // directly behind a store needs the turnaround bubble.
    assign turn_hit   = in_valid && (mem_mode == MEM_ST) && (mem_mode_in == MEM_LD)
                        && (data_s1_in[15] == data_s1[15]);
    assign mode_known = (mem_mode_in <= MEM_LD_IMM);

    // Next-state and handshake decode
    always_comb begin
        state_d  = RUN;
        in_ready = 1'b0;
        capture  = 1'b0;
        if (!rst) begin
            in_ready = 1'b1;
            if ((state_q == RUN) && turn_hit) begin
                in_ready = 1'b0;
                state_d  = TURN;
            end
            capture = in_ready && in_valid && mode_known;
        end
    end

    // State and instruction register; reset, then flush, win over capture
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q       <= RUN;
            alu_result    <= '0;
            data_s1       <= '0;
            data_s2       <= '0;
            mem_mode      <= MEM_NONE;
            write_back_en <= 1'b0;
            dest_reg      <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                alu_result    <= alu_result_in;
                data_s1       <= data_s1_in;
                data_s2       <= data_s2_in;
                mem_mode      <= mem_mode_in;
                write_back_en <= write_back_en_in;
                dest_reg      <= dest_reg_in;
            end else begin
                alu_result    <= '0;
                data_s1       <= '0;
                data_s2       <= '0;
                mem_mode      <= MEM_NONE;
                write_back_en <= 1'b0;
                dest_reg      <= '0;
            end
        end
    end

    // Hazard and bypass outputs from the held instruction; silenced in reset
    always_comb begin
        load_use_stall = 1'b0;
        fwd_valid      = 1'b0;
        fwd_reg        = dest_reg;
        fwd_data       = (mem_mode == MEM_LD_IMM) ? data_s1 : alu_result;
        if (!rst) begin
            load_use_stall = (mem_mode == MEM_LD)
                             && ((use_a && (src_a == dest_reg)) || (use_b && (src_b == dest_reg)));
            fwd_valid      = (write_back_en && (mem_mode == MEM_NONE)) || (mem_mode == MEM_LD_IMM);
        end
    end

endmodule

// File: tb/tb_dsp_ex_mem_stage.sv
// Randomised and directed bench for dsp_ex_mem_stage against a behavioural model.
module tb_dsp_ex_mem_stage;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] LD   = 3'd1;
    localparam logic [2:0] ST   = 3'd2;
    localparam logic [2:0] IMM  = 3'd3;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, write_back_en_in, use_a, use_b, flush;
    logic [15:0] alu_result_in, data_s1_in, data_s2_in;
    logic [2:0]  mem_mode_in;
    logic [3:0]  dest_reg_in, src_a, src_b;
    logic [15:0] alu_result, data_s1, data_s2, fwd_data;
    logic [2:0]  mem_mode;
    logic        write_back_en, load_use_stall, fwd_valid;
    logic [3:0]  dest_reg, fwd_reg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the held instruction
    logic [2:0]  m_mode;
    logic        m_wb;
    logic [3:0]  m_dest;
    logic [15:0] m_alu, m_s1, m_s2;

    always #5 clk = ~clk;

    dsp_ex_mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_in(alu_result_in), .data_s1_in(data_s1_in), .data_s2_in(data_s2_in),
        .mem_mode_in(mem_mode_in), .write_back_en_in(write_back_en_in), .dest_reg_in(dest_reg_in),
        .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b), .flush(flush),
        .alu_result(alu_result), .data_s1(data_s1), .data_s2(data_s2), .mem_mode(mem_mode),
        .write_back_en(write_back_en), .dest_reg(dest_reg), .load_use_stall(load_use_stall),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_bubble();
        m_mode = NONE; m_wb = 1'b0; m_dest = '0; m_alu = '0; m_s1 = '0; m_s2 = '0;
    endtask

    // Called at edge+1: apply inputs, check everything, clock, update model.
    task automatic step(input bit r, input bit fl, input bit v, input logic [2:0] mode,
                        input logic [15:0] alu, input logic [15:0] s1, input logic [15:0] s2,
                        input bit wb, input logic [3:0] dest, input logic [3:0] sa,
                        input logic [3:0] sb, input bit ua, input bit ub);
        bit exp_ready, exp_stall, exp_fv;
        rst = r; flush = fl; in_valid = v; mem_mode_in = mode; alu_result_in = alu;
        data_s1_in = s1; data_s2_in = s2; write_back_en_in = wb; dest_reg_in = dest;
        src_a = sa; src_b = sb; use_a = ua; use_b = ub;
        #2;
        exp_ready = !r && !(v && m_mode == ST && mode == LD && s1[15] == m_s1[15]);
        exp_stall = !r && m_mode == LD && ((ua && sa == m_dest) || (ub && sb == m_dest));
        exp_fv    = !r && ((m_wb && m_mode == NONE) || m_mode == IMM);
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("load_use_stall", load_use_stall, exp_stall);
        check_eq("fwd_valid", fwd_valid, exp_fv);
        if (exp_fv) begin
            check_eq("fwd_reg", fwd_reg, m_dest);
            check_eq("fwd_data", fwd_data, (m_mode == IMM) ? m_s1 : m_alu);
        end
        check_eq("mem_mode", mem_mode, m_mode);
        check_eq("write_back_en", write_back_en, m_wb);
        check_eq("dest_reg", dest_reg, m_dest);
        check_eq("alu_result", alu_result, m_alu);
        check_eq("data_s1", data_s1, m_s1);
        check_eq("data_s2", data_s2, m_s2);
        @(posedge clk);
        if (r || fl || !exp_ready || !v || mode > IMM) begin
            model_bubble();
        end else begin
            m_mode = mode; m_wb = wb; m_dest = dest; m_alu = alu; m_s1 = s1; m_s2 = s2;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, NONE, 16'h0, 16'h0, 16'h0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_mode_in = NONE; alu_result_in = '0;
        data_s1_in = '0; data_s2_in = '0; write_back_en_in = 1'b0; dest_reg_in = '0;
        src_a = '0; src_b = '0; use_a = 1'b0; use_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_bubble();
        step(1, 0, 1, NONE, 16'h1111, 16'h2, 16'h3, 1, 4'd1, 4'd0, 4'd0, 0, 0);

        // Plain ALU result with bypass
        step(0, 0, 1, NONE, 16'h1234, 16'h0, 16'h0, 1, 4'd3, 4'd0, 4'd0, 0, 0);
        check_eq("r29_alu", alu_result, 16'h1234);
        check_eq("r29_fwd_valid", fwd_valid, 1'b1);
        check_eq("r29_fwd_reg", fwd_reg, 4'd3);
        check_eq("r29_fwd_data", fwd_data, 16'h1234);
        idle();

        // Same-bank store->load turnaround, load re-presented after the bubble
        step(0, 0, 1, ST, 16'h0, 16'h0010, 16'hAAAA, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        step(0, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd6, 4'd0, 4'd0, 0, 0);
        check_eq("turn_bubble", mem_mode, NONE);
        step(0, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd6, 4'd0, 4'd0, 0, 0);
        check_eq("turn_load_out", mem_mode, LD);
        idle();
        // Other-bank load follows a store without a bubble
        step(0, 0, 1, ST, 16'h0, 16'h0010, 16'hAAAA, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        step(0, 0, 1, LD, 16'h0, 16'h8020, 16'h0, 1, 4'd6, 4'd0, 4'd0, 0, 0);
        check_eq("no_turn_load", mem_mode, LD);
        check_eq("no_turn_addr", data_s1, 16'h8020);

        // Load-use hazard on each operand
        step(0, 0, 1, LD, 16'h0, 16'h0040, 16'h0, 1, 4'd5, 4'd0, 4'd0, 0, 0);
        src_a = 4'd5; use_a = 1'b1; in_valid = 1'b0; #1;
        check_eq("stall_a", load_use_stall, 1'b1);
        use_a = 1'b0; #1;
        check_eq("stall_a_unused", load_use_stall, 1'b0);
        src_b = 4'd5; use_b = 1'b1; #1;
        check_eq("stall_b", load_use_stall, 1'b1);
        @(posedge clk); model_bubble(); #1;

        // Immediate load forwards; store does not
        step(0, 0, 1, IMM, 16'h0, 16'hBEEF, 16'h0, 1, 4'd7, 4'd0, 4'd0, 0, 0);
        check_eq("imm_fwd_valid", fwd_valid, 1'b1);
        check_eq("imm_fwd_data", fwd_data, 16'hBEEF);
        step(0, 0, 1, ST, 16'h0, 16'h0010, 16'h5, 1, 4'd7, 4'd0, 4'd0, 0, 0);
        check_eq("st_fwd_valid", fwd_valid, 1'b0);

        // Flush while in turnaround
        step(0, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd2, 4'd0, 4'd0, 0, 0);
        step(0, 1, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd2, 4'd0, 4'd0, 0, 0);
        check_eq("flush_bubble", mem_mode, NONE);
        check_eq("flush_ready", in_ready, 1'b1);
        idle();

        // Reset with a load held, and reset abandoning a turnaround
        step(0, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd5, 4'd0, 4'd0, 0, 0);
        step(1, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd5, 4'd5, 4'd0, 1, 0);
        step(1, 0, 0, NONE, 16'h0, 16'h0, 16'h0, 0, 4'd0, 4'd5, 4'd0, 1, 0);
        step(0, 0, 1, ST, 16'h0, 16'h0010, 16'h0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        step(0, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd4, 4'd0, 4'd0, 0, 0);
        step(1, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd4, 4'd0, 4'd0, 0, 0);
        step(0, 0, 1, LD, 16'h0, 16'h0020, 16'h0, 1, 4'd4, 4'd0, 4'd0, 0, 0);
        check_eq("reset_abandon_reload", mem_mode, LD);

        // Unrecognised encoding becomes a bubble
        step(0, 0, 1, 3'd6, 16'h7777, 16'h1, 16'h2, 1, 4'd9, 4'd0, 4'd0, 0, 0);
        check_eq("bad_mode_bubble", write_back_en, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] md;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)      md = LD;
            else if (sel < 6) md = ST;
            else if (sel == 6) md = NONE;
            else if (sel == 7) md = IMM;
            else              md = 3'($urandom_range(0, 7));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) != 0, md, 16'($urandom()),
                 {1'($urandom_range(0, 1)), 15'($urandom())}, 16'($urandom()),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
